// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Issues in-order requests to instruction memory and buffers up to two
// {instr, PC} pairs for the F/D register. Redirects flush the buffer and
// drop responses that are still outstanding.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN adds F_misalign_o and
// blocks fetch after a misaligned redirect until an aligned one arrives.

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module fetch_unit #(
    parameter logic [`PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    F_stall_i,
    input  logic                    redirect_valid_i,
    input  logic [`PC_WIDTH-1:0]    redirect_pc_i,
    output logic                    imem_req_o,
    output logic [`PC_WIDTH-1:0]    imem_addr_o,
    input  logic                    imem_ready_i,
    input  logic                    imem_rvalid_i,
    input  logic [`INSTR_WIDTH-1:0] imem_rdata_i,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic                    F_misalign_o,
`endif
    output logic                    F_valid_o,
    output logic [`INSTR_WIDTH-1:0] instr_o,
    output logic [`PC_WIDTH-1:0]    F_PC_o
);

    localparam int unsigned PcW    = `PC_WIDTH;
    localparam int unsigned InstrW = `INSTR_WIDTH;

    // Fetch PC and 2-entry instruction queue
    logic [PcW-1:0]    pc_q, pc_d;
    logic [InstrW-1:0] q_instr_q [2];
    logic [InstrW-1:0] q_instr_d [2];
    logic [PcW-1:0]    q_pc_q [2];
    logic [PcW-1:0]    q_pc_d [2];
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        count_q, count_d;

    // Outstanding requests and how many of their responses must be dropped
    logic [1:0]        inflight_q, inflight_d;
    logic [1:0]        discard_q, discard_d;

    logic              rsp_live;
    logic              rsp_keep;
    logic [1:0]        live_cnt;
    logic [PcW-1:0]    rsp_pc;
    logic [2:0]        occupancy;
    logic              req;
    logic              accept;
    logic              head_valid;
    logic              pop;
    logic              push;
    logic [PcW-1:0]    redirect_tgt;
    logic              blocked;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic              misalign_q, misalign_d;

    // Misaligned targets are kept as-is; fetch stays blocked until realigned
    assign redirect_tgt = redirect_pc_i;
    assign blocked      = misalign_q;
    assign F_misalign_o = misalign_q;

    // Flag tracks the alignment of the most recent redirect target
    always_comb begin
        misalign_d = misalign_q;
        if (redirect_valid_i) begin
            misalign_d = |redirect_pc_i[1:0];
        end
    end

    // Misalign flag register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`else
    assign redirect_tgt = redirect_pc_i & ~PcW'(3);
    assign blocked      = 1'b0;
`endif

    // Request/response qualification and response PC reconstruction
    always_comb begin
        // A response with nothing outstanding belongs to a pre-reset request
        rsp_live   = imem_rvalid_i && (inflight_q != 2'd0);
        rsp_keep   = rsp_live && (discard_q == 2'd0);
        // Kept requests are consecutive words ending just below pc_q
        live_cnt   = inflight_q - discard_q;
        rsp_pc     = pc_q - (PcW'(live_cnt) << 2);
        occupancy  = {1'b0, inflight_q} + {1'b0, count_q};
        req        = !rst_i && !redirect_valid_i && !blocked && (occupancy < 3'd2);
        accept     = req && imem_ready_i;
        head_valid = (count_q != 2'd0);
        pop        = head_valid && !F_stall_i && !redirect_valid_i;
        push       = rsp_keep && !redirect_valid_i;
    end

    // Next-state for PC, queue and counters; redirect overrides everything
    always_comb begin
        pc_d       = pc_q;
        q_instr_d  = q_instr_q;
        q_pc_d     = q_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        discard_d  = discard_q;
        inflight_d = inflight_q - {1'b0, rsp_live} + {1'b0, accept};

        if (redirect_valid_i) begin
            // Everything still outstanding after this cycle is stale
            rd_ptr_d  = 1'b0;
            wr_ptr_d  = 1'b0;
            count_d   = 2'd0;
            discard_d = inflight_d;
            pc_d      = redirect_tgt;
        end else begin
            if (rsp_live && (discard_q != 2'd0)) begin
                discard_d = discard_q - 2'd1;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (push) begin
                q_instr_d[wr_ptr_q] = imem_rdata_i;
                q_pc_d[wr_ptr_q]    = rsp_pc;
                wr_ptr_d            = ~wr_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            if (accept) begin
                pc_d = pc_q + PcW'(4);
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            q_instr_q  <= '{default: '0};
            q_pc_q     <= '{default: '0};
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= 2'd0;
            inflight_q <= 2'd0;
            discard_q  <= 2'd0;
        end else begin
            pc_q       <= pc_d;
            q_instr_q  <= q_instr_d;
            q_pc_q     <= q_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    // Outputs: head of queue, zeroed when empty
    always_comb begin
        imem_req_o  = req;
        imem_addr_o = pc_q;
        F_valid_o   = head_valid;
        instr_o     = head_valid ? q_instr_q[rd_ptr_q] : '0;
        F_PC_o      = head_valid ? q_pc_q[rd_ptr_q] : '0;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized traffic,
// checked against a transaction-level model of requests and deliveries.

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef INSTR_WIDTH
`define INSTR_WIDTH 32
`endif

module tb_fetch_unit;

    localparam logic [31:0] ResetPc = 32'h100;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        fvalid;
    logic [31:0] instr;
    logic [31:0] fpc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        mis;
`endif

    fetch_unit #(
        .RESET_PC(ResetPc)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .F_stall_i       (stall),
        .redirect_valid_i(redir),
        .redirect_pc_i   (rpc),
        .imem_req_o      (req),
        .imem_addr_o     (addr),
        .imem_ready_i    (ready),
        .imem_rvalid_i   (rvalid),
        .imem_rdata_i    (rdata),
`ifdef FETCH_MISALIGN_TRAP_EN
        .F_misalign_o    (mis),
`endif
        .F_valid_o       (fvalid),
        .instr_o         (instr),
        .F_PC_o          (fpc)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: accepted-but-unanswered requests, and instructions awaiting pickup
    logic [31:0] pend_addr[$];
    bit          pend_stale[$];
    logic [31:0] outq[$];
    logic [31:0] m_pc;
    bit          m_mis;
    int          cyc;
    int          first_acc;
    int          first_val;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0000;
    endfunction

    task automatic model_reset();
        pend_addr.delete();
        pend_stale.delete();
        outq.delete();
        m_pc      = ResetPc;
        m_mis     = 1'b0;
        cyc       = 0;
        first_acc = -1;
        first_val = -1;
    endtask

    // Check DUT outputs against the model, then advance the model by one cycle
    task automatic model_cycle();
        bit          exp_req;
        bit          exp_v;
        bit          have_rsp;
        bit          st;
        logic [31:0] a;
        exp_req = !redir && ((pend_addr.size() + outq.size()) < 2) && !m_mis;
        exp_v   = outq.size() > 0;
        check_eq("imem_req", req, exp_req);
        if (exp_req) check_eq("imem_addr", addr, m_pc);
        check_eq("f_valid", fvalid, exp_v);
        check_eq("f_pc", fpc, exp_v ? outq[0] : 32'h0);
        check_eq("instr", instr, exp_v ? word_at(outq[0]) : 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_eq("misalign", mis, m_mis);
`endif
        if (exp_v && first_val < 0) first_val = cyc;
        have_rsp = rvalid && (pend_addr.size() > 0);
        st = 1'b0;
        a  = '0;
        if (have_rsp) begin
            a  = pend_addr.pop_front();
            st = pend_stale.pop_front();
        end
        if (redir) begin
            foreach (pend_stale[i]) pend_stale[i] = 1'b1;
            outq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
            m_pc  = rpc;
            m_mis = (rpc[1:0] != 2'b00);
`else
            m_pc  = rpc & ~32'h3;
`endif
        end else begin
            if (exp_v && !stall) void'(outq.pop_front());
            if (have_rsp && !st) outq.push_back(a);
            if (exp_req && ready) begin
                pend_addr.push_back(m_pc);
                pend_stale.push_back(1'b0);
                m_pc = m_pc + 32'h4;
                if (first_acc < 0) first_acc = cyc;
            end
        end
        cyc++;
    endtask

    // One clock of stimulus; rvalid with nothing outstanding is a stray response
    task automatic step(input bit s, input bit rd, input logic [31:0] tgt, input bit rdy,
                        input bit rv);
        @(posedge clk);
        #1;
        stall  = s;
        redir  = rd;
        rpc    = tgt;
        ready  = rdy;
        rvalid = rv;
        rdata  = (pend_addr.size() > 0) ? word_at(pend_addr[0]) : $urandom;
        @(negedge clk);
        model_cycle();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst    = 1'b1;
        stall  = 1'b0;
        redir  = 1'b0;
        rpc    = '0;
        ready  = 1'b0;
        rvalid = 1'b0;
        #2;
        check_eq("rst_req", req, 1'b0);
        check_eq("rst_valid", fvalid, 1'b0);
        check_eq("rst_instr", instr, 32'h0);
        check_eq("rst_pc", fpc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_req", req, 1'b1);
        check_eq("post_rst_addr", addr, ResetPc);
        model_reset();
    endtask

    initial begin
        rst    = 1'b1;
        stall  = 1'b0;
        redir  = 1'b0;
        rpc    = '0;
        ready  = 1'b0;
        rvalid = 1'b0;
        rdata  = '0;
        model_reset();
        repeat (2) @(posedge clk);

        // Streaming after reset: 2-cycle latency from first acceptance
        do_reset();
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("first_acc_cycle", first_acc, 0);
        check_eq("latency", first_val - first_acc, 2);

        // Held stall: queue fills, requests stop, head unchanged
        do_reset();
        repeat (5) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("stall_head_pc", fpc, ResetPc);
        check_eq("stall_head_valid", fvalid, 1'b1);
        check_eq("stall_req_low", req, 1'b0);

        // Redirect with two requests in flight: late responses dropped
        do_reset();
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h200, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            if (fvalid) break;
        end
        check_eq("redir_head_valid", fvalid, 1'b1);
        check_eq("redir_head_pc", fpc, 32'h200);

        // Redirect, stall and response in one cycle
        do_reset();
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h300, 1'b1, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("combo_valid", fvalid, 1'b0);
        check_eq("combo_addr", addr, 32'h300);

        // Memory not ready: address held, PC not advanced
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            check_eq("wait_addr", addr, ResetPc);
        end
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("after_wait_addr", addr, ResetPc + 32'h4);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect blocks fetch until an aligned redirect
        do_reset();
        step(1'b0, 1'b1, 32'h202, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("mis_flag", mis, 1'b1);
        check_eq("mis_no_req", req, 1'b0);
        step(1'b0, 1'b1, 32'h300, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("mis_clear", mis, 1'b0);
        check_eq("mis_refetch_req", req, 1'b1);
        check_eq("mis_refetch_addr", addr, 32'h300);
`endif

        // Randomized traffic, including occasional wrap-around targets and resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 7) == 0) tgt = 32'hffff_fff0 | (tgt & 32'hf);
`ifdef FETCH_MISALIGN_TRAP_EN
            if ($urandom_range(0, 3) != 0) tgt = tgt & ~32'h3;
`endif
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, tgt,
                     $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
